axis_cam_tx: RTL



---
 rtl/cam_link_pkg.sv | 29 ++
 rtl/cam_data_packer.sv | 28 ++
 rtl/axis_cam_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cam_link_pkg.sv
// Shared CameraLink Base definitions: FSM state encoding for the transmit
// path and the serializer bit positions, common to the receive-side parser.
package cam_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FV_LEAD  = 3'd1,
        ST_LINE     = 3'd2,
        ST_DISCARD  = 3'd3,
        ST_HBLANK   = 3'd4,
        ST_FV_TRAIL = 3'd5,
        ST_VBLANK   = 3'd6
    } cam_state_t;

    localparam int CL_WORD_W   = 28;
    localparam int CL_SPARE_BIT = 23;
    localparam int CL_LVAL_BIT = 24;
    localparam int CL_FVAL_BIT = 25;
    localparam int CL_DVAL_BIT = 26;

    // Element i is the serializer bit that carries port bit i.
    localparam logic [7:0][4:0] CL_PORT_A_MAP =
        {5'd5, 5'd27, 5'd6, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [7:0][4:0] CL_PORT_B_MAP =
        {5'd11, 5'd10, 5'd14, 5'd13, 5'd12, 5'd9, 5'd8, 5'd7};
    localparam logic [7:0][4:0] CL_PORT_C_MAP =
        {5'd17, 5'd16, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd15};

endpackage

// File: rtl/cam_data_packer.sv
// Combinational CameraLink word builder: scatters ports A/B/C and the
// three timing flags into the serializer bit order. Bit 23 stays 0.
module cam_data_packer
    import cam_link_pkg::*;
(
    input  logic [7:0]           port_a,
    input  logic [7:0]           port_b,
    input  logic [7:0]           port_c,
    input  logic                 lval,
    input  logic                 fval,
    input  logic                 dval,
    output logic [CL_WORD_W-1:0] cam_word
);

    // Scatter every port bit to its serializer position, then add timing.
    always_comb begin
        cam_word = '0;
        for (int i = 0; i < 8; i++) begin
            cam_word[CL_PORT_A_MAP[i]] = port_a[i];
            cam_word[CL_PORT_B_MAP[i]] = port_b[i];
            cam_word[CL_PORT_C_MAP[i]] = port_c[i];
        end
        cam_word[CL_LVAL_BIT] = lval;
        cam_word[CL_FVAL_BIT] = fval;
        cam_word[CL_DVAL_BIT] = dval;
    end

endmodule

// File: rtl/axis_cam_tx.sv
// AXI4-Stream 24-bit video to CameraLink Base transmitter. Generates
// FVAL/LVAL/DVAL with programmable blanking and registers the packed word.
//
// Handshake: a beat transfers on a rising aclk edge where s_axis_tvalid and
// s_axis_tready are both 1. tready is 0 during reset and on the first cycle
// after release; it is also pulled low combinationally whenever the beat on
// the bus carries a tuser that must start a new frame (held, not consumed).
module axis_cam_tx
    import cam_link_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 64,
    parameter int FV_SETUP    = 4,
    parameter int DATA_WIDTH  = 24
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [CL_WORD_W-1:0]  cam_data_out,
    output logic                  underrun,
    output logic                  line_err,
    output logic                  frame_err,
    output logic [2:0]            dbg_state
);

    localparam int PIX_W   = $clog2(LINE_PIXELS + 1);
    localparam int LINE_W  = $clog2(FRAME_LINES + 1);
    localparam int BLK_MAX = (H_BLANK > V_BLANK) ?
                             ((H_BLANK > FV_SETUP) ? H_BLANK : FV_SETUP) :
                             ((V_BLANK > FV_SETUP) ? V_BLANK : FV_SETUP);
    localparam int BLK_W   = $clog2(BLK_MAX + 1);

    cam_state_t           state_q, state_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [LINE_W-1:0]    line_q, line_d, line_nx;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic                 run_q;
    logic                 ready_c, lval_c, fval_c, dval_c;
    logic                 ur_c, le_c, fe_c, line_end;
    logic [23:0]          pix_c;
    logic [CL_WORD_W-1:0] word_c;

    assign line_nx       = line_q + LINE_W'(1);
    assign s_axis_tready = ready_c & run_q;
    assign dbg_state     = state_q;
    assign pix_c         = dval_c ? s_axis_tdata[23:0] : 24'h0;

    // Next state, counters and per-cycle timing flags.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        line_d   = line_q;
        blk_d    = blk_q;
        ready_c  = 1'b0;
        lval_c   = 1'b0;
        fval_c   = 1'b0;
        dval_c   = 1'b0;
        ur_c     = 1'b0;
        le_c     = 1'b0;
        fe_c     = 1'b0;
        line_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tuser && run_q) begin
                    ready_c = 1'b0;
                    state_d = ST_FV_LEAD;
                    blk_d   = '0;
                    line_d  = '0;
                end
            end
            ST_FV_LEAD: begin
                fval_c = 1'b1;
                if (blk_q == BLK_W'(FV_SETUP - 1)) begin
                    state_d = ST_LINE;
                    blk_d   = '0;
                    pix_d   = '0;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            ST_LINE: begin
                fval_c  = 1'b1;
                lval_c  = 1'b1;
                ready_c = 1'b1;
                if (!s_axis_tvalid) begin
                    ur_c = 1'b1;
                end else if (s_axis_tuser && (pix_q != '0 || line_q != '0)) begin
                    // New frame arrived early: hold the beat, close this frame.
                    ready_c = 1'b0;
                    fe_c    = 1'b1;
                    state_d = ST_FV_TRAIL;
                    blk_d   = '0;
                end else begin
                    dval_c = 1'b1;
                    if (s_axis_tlast) begin
                        le_c     = (pix_q != PIX_W'(LINE_PIXELS - 1));
                        line_end = 1'b1;
                    end else if (pix_q == PIX_W'(LINE_PIXELS - 1)) begin
                        le_c    = 1'b1;
                        state_d = ST_DISCARD;
                        blk_d   = '0;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            ST_DISCARD: begin
                fval_c  = 1'b1;
                ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tuser) begin
                    ready_c = 1'b0;
                    fe_c    = 1'b1;
                    state_d = ST_FV_TRAIL;
                    blk_d   = '0;
                end else if (s_axis_tvalid && s_axis_tlast) begin
                    line_end = 1'b1;
                end
            end
            ST_HBLANK: begin
                fval_c = 1'b1;
                if (blk_q == BLK_W'(H_BLANK - 1)) begin
                    state_d = ST_LINE;
                    blk_d   = '0;
                    pix_d   = '0;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            ST_FV_TRAIL: begin
                fval_c = 1'b1;
                if (blk_q == BLK_W'(FV_SETUP - 1)) begin
                    state_d = ST_VBLANK;
                    blk_d   = '0;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            ST_VBLANK: begin
                if (blk_q == BLK_W'(V_BLANK - 1)) begin
                    state_d = ST_IDLE;
                    blk_d   = '0;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                blk_d   = '0;
            end
        endcase
        if (line_end) begin
            line_d  = line_nx;
            pix_d   = '0;
            blk_d   = '0;
            state_d = (line_nx == LINE_W'(FRAME_LINES)) ? ST_FV_TRAIL : ST_HBLANK;
        end
    end

    cam_data_packer u_packer (
        .port_a   (pix_c[7:0]),
        .port_b   (pix_c[15:8]),
        .port_c   (pix_c[23:16]),
        .lval     (lval_c),
        .fval     (fval_c),
        .dval     (dval_c),
        .cam_word (word_c)
    );

    // State and counter registers; run_q keeps tready low until out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            line_q  <= '0;
            blk_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            blk_q   <= blk_d;
            run_q   <= 1'b1;
        end
    end

    // Registered serializer word and status pulses, one cycle after the beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cam_data_out <= '0;
            underrun     <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cam_data_out <= word_c;
            underrun     <= ur_c;
            line_err     <= le_c;
            frame_err    <= fe_c;
        end
    end

endmodule
